// File: rtl/rv_dmem_arbiter_pkg.sv
// Shared constants, owner encoding, error causes and bundles
// for the two-port data-memory arbiter.
package rv_dmem_arbiter_pkg;

  localparam int unsigned DMEM_WORDS = 1024;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_1000;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_P0   = 2'b01;
  localparam logic [1:0] OWN_P1   = 2'b10;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_LOW   = 2'd2,
    ERR_HIGH  = 2'd3
  } err_cause_e;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } drsp_t;

  function automatic err_cause_e err_cause(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] words
  );
    logic [31:0] lim;
    lim = base + (words << 2);
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if (addr < base)        return ERR_LOW;
    if (addr >= lim)        return ERR_HIGH;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/rv_dmem_arbiter_if.sv
// Requester and memory bus of the data-memory arbiter.
// slave = arbiter side, master = requesters plus memory.
interface rv_dmem_arbiter_if;

  logic        p0_req;
  logic        p0_we;
  logic        p0_lock;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic        p1_lock;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_lock,
    input  p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid,
    output p0_rdata, p0_err,
    input  p1_req, p1_we, p1_lock,
    input  p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid,
    output p1_rdata, p1_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_lock,
    output p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid,
    input  p0_rdata, p0_err,
    output p1_req, p1_we, p1_lock,
    output p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid,
    input  p1_rdata, p1_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rv_rr_arb2.sv
// Two-way round-robin picker; a set lock owner
// excludes the other requester entirely.
module rv_rr_arb2
  import rv_dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] lock_owner,
  output logic [1:0] gnt
);

  logic free;

  assign free = (lock_owner == OWN_NONE);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      lock_owner == OWN_P0:
        gnt = {1'b0, req[0]};
      lock_owner == OWN_P1:
        gnt = {req[1], 1'b0};
      free && (req == 2'b11):
        gnt = last ? 2'b01 : 2'b10;
      default:
        gnt = free ? req : 2'b00;
    endcase
  end

endmodule

// File: rtl/rv_dmem_arbiter.sv
// Shares a comb-read / sync-write data memory between the LSU
// (port 0) and the FP-multiply engine (port 1).
module rv_dmem_arbiter
  import rv_dmem_arbiter_pkg::*;
#(
  parameter int unsigned WORDS = DMEM_WORDS,
  parameter logic [31:0] BASE  = DMEM_BASE
) (
  input logic         clk,
  input logic         rst,
  rv_dmem_arbiter_if.slave bus
);

  logic       last_q;
  logic       last_d;
  logic [1:0] owner_q;
  logic [1:0] owner_d;
  drsp_t      rsp0_q;
  drsp_t      rsp0_d;
  drsp_t      rsp1_q;
  drsp_t      rsp1_d;

  logic [1:0]  req;
  logic [1:0]  pick;
  logic [1:0]  gnt;
  logic        grant;
  dreq_t       r0;
  dreq_t       r1;
  dreq_t       win;
  err_cause_e  cause;
  logic        acc_err;
  logic [31:0] rd_val;

  assign req = {bus.p1_req, bus.p0_req};

  rv_rr_arb2 u_rr (
    .req        (req),
    .last       (last_q),
    .lock_owner (owner_q),
    .gnt        (pick)
  );

  // Reset also blocks the grant, so a write in that cycle never lands.
  assign gnt   = rst ? 2'b00 : pick;
  assign grant = |gnt;

  always_comb begin
    r0.we    = bus.p0_we;
    r0.lock  = bus.p0_lock;
    r0.addr  = bus.p0_addr;
    r0.wdata = bus.p0_wdata;
    r1.we    = bus.p1_we;
    r1.lock  = bus.p1_lock;
    r1.addr  = bus.p1_addr;
    r1.wdata = bus.p1_wdata;
  end

  assign win     = gnt[1] ? r1 : r0;
  assign cause   = err_cause(win.addr, BASE, 32'(WORDS));
  assign acc_err = (cause != ERR_NONE);

  assign bus.mem_we    = grant & win.we & ~acc_err;
  assign bus.mem_addr  = grant ? win.addr : '0;
  assign bus.mem_wdata = grant ? win.wdata : '0;

  assign rd_val = (win.we | acc_err) ? '0 : bus.mem_rdata;

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;

    rsp0_d.rvalid = gnt[0];
    rsp0_d.err    = gnt[0] & acc_err;
    rsp0_d.rdata  = gnt[0] ? rd_val : '0;
    rsp1_d.rvalid = gnt[1];
    rsp1_d.err    = gnt[1] & acc_err;
    rsp1_d.rdata  = gnt[1] ? rd_val : '0;

    if (grant) begin
      last_d  = gnt[1];
      owner_d = !win.lock ? OWN_NONE :
                gnt[1]    ? OWN_P1 : OWN_P0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= 1'b1;
      owner_q <= OWN_NONE;
      rsp0_q  <= '0;
      rsp1_q  <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

  assign bus.p0_gnt    = gnt[0];
  assign bus.p0_rvalid = rsp0_q.rvalid;
  assign bus.p0_err    = rsp0_q.err;
  assign bus.p0_rdata  = rsp0_q.rdata;
  assign bus.p1_gnt    = gnt[1];
  assign bus.p1_rvalid = rsp1_q.rvalid;
  assign bus.p1_err    = rsp1_q.err;
  assign bus.p1_rdata  = rsp1_q.rdata;

endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Bench for rv_dmem_arbiter: queue-fed requesters, a memory
// beside the DUT and a transaction-level reference model.
module tb_rv_dmem_arbiter;

  localparam int          W = 1024;
  localparam logic [31:0] B = 32'h0000_1000;

  typedef struct {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_dmem_arbiter_if bus ();

  rv_dmem_arbiter #(
    .WORDS (W),
    .BASE  (B)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   ncmp = 0;
  int   nbad = 0;
  int   cyc  = 0;
  txn_t q0[$];
  txn_t q1[$];
  logic [1:0] gseen = 2'b00;
  int   gport[$];
  int   gcyc[$];
  int   we_cnt = 0;

  function automatic logic [31:0] init_val(int i);
    return 32'h4000_0000 + (32'(i) << 22);
  endfunction

  function automatic int widx(logic [31:0] a);
    logic [31:0] o;
    o = a - B;
    return int'(o[11:2]);
  endfunction

  function automatic bit bad_addr(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < B) ||
           (a >= B + 32'(4 * W));
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s cyc %0d: got %h want %h",
               nm, cyc, got, exp);
    end
  endtask

  // memory beside the arbiter: comb read, sync write
  logic [31:0] mem [W];
  bit          mem_ok = 0;
  assign bus.mem_rdata = mem[widx(bus.mem_addr)];

  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < W; i++) mem[i] <= init_val(i);
      mem_ok <= 1'b1;
    end else if (bus.mem_we) begin
      mem[widx(bus.mem_addr)] <= bus.mem_wdata;
    end
  end

  // requesters: hold the queue head until it is granted
  always @(posedge clk) begin
    #1;
    if (gseen[0] && q0.size() > 0) void'(q0.pop_front());
    if (gseen[1] && q1.size() > 0) void'(q1.pop_front());
    bus.p0_req   = q0.size() > 0;
    bus.p0_we    = q0.size() > 0 ? q0[0].we    : 1'b0;
    bus.p0_lock  = q0.size() > 0 ? q0[0].lock  : 1'b0;
    bus.p0_addr  = q0.size() > 0 ? q0[0].addr  : 32'h0;
    bus.p0_wdata = q0.size() > 0 ? q0[0].wdata : 32'h0;
    bus.p1_req   = q1.size() > 0;
    bus.p1_we    = q1.size() > 0 ? q1[0].we    : 1'b0;
    bus.p1_lock  = q1.size() > 0 ? q1[0].lock  : 1'b0;
    bus.p1_addr  = q1.size() > 0 ? q1[0].addr  : 32'h0;
    bus.p1_wdata = q1.size() > 0 ? q1[0].wdata : 32'h0;
  end

  // reference model: tie-break turn, owner (-1 = none), memory copy
  int          turn  = 0;
  int          owner = -1;
  logic [31:0] ref_mem [W];
  bit          ref_ok = 0;
  logic [1:0]  erv = 2'b00;
  logic [1:0]  eerr = 2'b00;
  logic [31:0] erd [2];
  int          waitc [2];
  logic [1:0]  m_req;
  logic [1:0]  m_dg;
  int          m_g;
  logic        m_we;
  logic        m_lk;
  logic        m_bad;
  logic [31:0] m_a;
  logic [31:0] m_wd;

  always @(negedge clk) begin
    cyc++;
    if (!ref_ok) begin
      for (int i = 0; i < W; i++) ref_mem[i] = init_val(i);
      ref_ok = 1;
    end
    m_dg = {bus.p1_gnt, bus.p0_gnt};
    if (rst) begin
      chk("rst gnt", m_dg, 0);
      chk("rst rvalid", {bus.p1_rvalid, bus.p0_rvalid}, 0);
      chk("rst err", {bus.p1_err, bus.p0_err}, 0);
      chk("rst p0_rdata", bus.p0_rdata, 0);
      chk("rst p1_rdata", bus.p1_rdata, 0);
      chk("rst mem_we", bus.mem_we, 0);
      turn  = 0;
      owner = -1;
      erv   = 2'b00;
      eerr  = 2'b00;
      gseen = 2'b00;
      waitc[0] = 0;
      waitc[1] = 0;
    end else begin
      chk("p0_rvalid", bus.p0_rvalid, erv[0]);
      chk("p1_rvalid", bus.p1_rvalid, erv[1]);
      if (erv[0]) begin
        chk("p0_rdata", bus.p0_rdata, erd[0]);
        chk("p0_err", bus.p0_err, eerr[0]);
      end
      if (erv[1]) begin
        chk("p1_rdata", bus.p1_rdata, erd[1]);
        chk("p1_err", bus.p1_err, eerr[1]);
      end
      m_req = {bus.p1_req, bus.p0_req};
      if (owner >= 0)        m_g = m_req[owner] ? owner : -1;
      else if (m_req == 3)   m_g = turn;
      else if (m_req[0])     m_g = 0;
      else if (m_req[1])     m_g = 1;
      else                   m_g = -1;
      chk("gnt", m_dg, m_g < 0 ? 32'd0 : 32'(1 << m_g));
      gseen = m_dg;
      for (int p = 0; p < 2; p++) begin
        if (m_req[p] && owner < 0 && !m_dg[p]) waitc[p]++;
        else waitc[p] = 0;
        if (m_req[p] && owner < 0)
          chk("starve", 32'(waitc[p] > 2), 0);
      end
      erv  = 2'b00;
      eerr = 2'b00;
      erd[0] = 32'h0;
      erd[1] = 32'h0;
      if (m_g >= 0) begin
        m_we  = m_g ? bus.p1_we    : bus.p0_we;
        m_lk  = m_g ? bus.p1_lock  : bus.p0_lock;
        m_a   = m_g ? bus.p1_addr  : bus.p0_addr;
        m_wd  = m_g ? bus.p1_wdata : bus.p0_wdata;
        m_bad = bad_addr(m_a);
        chk("mem_addr", bus.mem_addr, m_a);
        chk("mem_we", bus.mem_we, m_we && !m_bad);
        if (m_we && !m_bad) begin
          chk("mem_wdata", bus.mem_wdata, m_wd);
          ref_mem[widx(m_a)] = m_wd;
        end
        erv[m_g]  = 1'b1;
        eerr[m_g] = m_bad;
        erd[m_g]  = (m_we || m_bad) ? 32'h0 : ref_mem[widx(m_a)];
        turn  = 1 - m_g;
        owner = m_lk ? m_g : -1;
        gport.push_back(m_g);
        gcyc.push_back(cyc);
      end else begin
        chk("idle mem_we", bus.mem_we, 0);
        chk("idle mem_addr", bus.mem_addr, 0);
      end
      if (bus.mem_we) we_cnt++;
    end
  end

  task automatic push(int p, logic we, logic lk,
                      logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.we = we;
    t.lock = lk;
    t.addr = a;
    t.wdata = d;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
  endtask

  task automatic wait_rsp(int p, output logic [31:0] d,
                          output logic e);
    int n;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (p == 0 ? bus.p0_rvalid : bus.p1_rvalid) break;
    end
    if (n == 20) begin
      ncmp++;
      nbad++;
      $display("FAIL rsp timeout port %0d cyc %0d", p, cyc);
    end
    d = p == 0 ? bus.p0_rdata : bus.p1_rdata;
    e = p == 0 ? bus.p0_err : bus.p1_err;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    if (n == 200) begin
      ncmp++;
      nbad++;
      $display("FAIL drain timeout cyc %0d", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.lock  = ($urandom_range(0, 7) == 0);
    t.wdata = $urandom;
    t.addr  = B + 32'(4 * $urandom_range(0, 15));
    case ($urandom_range(0, 11))
      0: t.addr = t.addr + 32'($urandom_range(1, 3));
      1: t.addr = B - 32'd4;
      2: t.addr = B + 32'(4 * W);
      3: t.addr = 32'hFFFF_FFFC;
      4: t.addr = B + 32'(4 * (W - 1));
      default: ;
    endcase
    return t;
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    logic [3:0]  ord;
    int          wc;

    repeat (3) @(negedge clk);
    chk("reset p0_gnt", bus.p0_gnt, 0);
    chk("reset p1_rvalid", bus.p1_rvalid, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: alternating reads
    gport.delete();
    gcyc.delete();
    push(0, 0, 0, B, 0);
    push(0, 0, 0, B + 4, 0);
    push(1, 0, 0, B, 0);
    push(1, 0, 0, B + 4, 0);
    wait_rsp(0, d, e); chk("t1 p0 rd0", d, 32'h4000_0000);
    wait_rsp(1, d, e); chk("t1 p1 rd0", d, 32'h4000_0000);
    wait_rsp(0, d, e); chk("t1 p0 rd1", d, 32'h4040_0000);
    wait_rsp(1, d, e); chk("t1 p1 rd1", d, 32'h4040_0000);
    drain();
    chk("t1 ngnt", gport.size(), 4);
    if (gport.size() == 4) begin
      for (int i = 0; i < 4; i++) ord[3-i] = gport[i][0];
      chk("t1 order", ord, 4'b0101);
    end

    // 2: read right after a write to the same word
    push(1, 1, 0, B + 8, 32'h40C0_0000);
    @(negedge clk);
    push(0, 0, 0, B + 8, 0);
    wait_rsp(0, d, e);
    chk("t2 rdata", d, 32'h40C0_0000);
    chk("t2 err", e, 0);
    drain();

    // 3: misaligned, below base, past end
    wc = we_cnt;
    push(0, 0, 0, B + 2, 0);
    push(0, 0, 0, B - 4, 0);
    push(0, 0, 0, B + 32'h1000, 0);
    for (int i = 0; i < 3; i++) begin
      wait_rsp(0, d, e);
      chk("t3 err", e, 1);
      chk("t3 rdata", d, 0);
    end
    drain();
    chk("t3 no write", we_cnt, wc);

    // 4: lock held by p1 starves p0 until the unlock grant
    gport.delete();
    gcyc.delete();
    push(1, 0, 1, B + 8, 0);
    @(negedge clk);
    repeat (3) push(0, 0, 0, B, 0);
    repeat (6) @(negedge clk);
    chk("t4 locked", gport.size(), 1);
    push(1, 1, 0, B + 8, 32'h4100_0000);
    drain();
    chk("t4 ngnt", gport.size(), 5);
    if (gport.size() == 5) begin
      chk("t4 unlock", gport[1], 1);
      chk("t4 p0 next", gport[2], 0);
      chk("t4 p0 cyc", gcyc[2] - gcyc[1], 1);
    end

    // 5: reset over a pending write and a pending response
    push(1, 0, 0, B + 12, 0);
    @(negedge clk);
    push(0, 1, 0, B + 4, 32'hDEAD_BEEF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5 p0_gnt", bus.p0_gnt, 0);
    chk("t5 p1_rvalid", bus.p1_rvalid, 0);
    chk("t5 p1_rdata", bus.p1_rdata, 0);
    chk("t5 mem_we", bus.mem_we, 0);
    @(negedge clk);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    gport.delete();
    gcyc.delete();
    push(0, 0, 0, B + 4, 0);
    push(1, 0, 0, B + 4, 0);
    wait_rsp(0, d, e); chk("t5 p0 rd", d, 32'h4040_0000);
    wait_rsp(1, d, e); chk("t5 p1 rd", d, 32'h4040_0000);
    drain();
    chk("t5 ngnt", gport.size(), 2);
    if (gport.size() > 0) chk("t5 first", gport[0], 0);

    // 6: random traffic
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (q0.size() < 2 && $urandom_range(0, 3) != 0)
        q0.push_back(rnd_txn());
      if (q1.size() < 2 && $urandom_range(0, 3) != 0)
        q1.push_back(rnd_txn());
    end
    push(0, 0, 0, B, 0);
    push(1, 0, 0, B, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
